dvs_aer_event_transmitter: RTL and testbench
============================================

Name: dvs_aer_event_transmitter

Overview:
- Synthesizable AER sender: takes pixel events over a valid/ready interface and drives the DVS-style AER bus (aer, xsel, req) toward an AER receiver, completing the four-phase handshake on ack.
- Used as a DVS camera emulator on FPGA and as a bus-functional driver in system sims feeding dvs_aer_to_event_interface.
- Suppresses repeated Y words when consecutive events share a row, matching camera row-burst behaviour.
- Enforces minimum event spacing, equivalent to the camera's 12 MHz readout limit.

Parameters:
- SETUP_CYCLES, 6, cycles aer/xsel are held stable before req rises. At 10 ns per cycle this gives at least 50 ns before a Y read.
- MIN_EVENT_CYCLES, 9, minimum cycles from one event accept to the next accept.
- Y_REPEAT_TIMEOUT, 100, idle cycles after which the stored row is invalidated and the next event always sends Y.
- ACK_TIMEOUT_CYCLES, 255, cycles req may stay high without ack before the block aborts.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- ev_valid  input  1  event offered
- ev_ready  output  1  block can accept an event
- ev_x  input  9  pixel column
- ev_y  input  9  pixel row
- ev_pol  input  1  polarity
- ack  input  1  AER acknowledge from receiver; asynchronous
- aer  output  10  AER data bus
- xsel  output  1  0 = Y word, 1 = X word
- req  output  1  AER request
- busy  output  1  high whenever state != IDLE
- range_err  output  1  one-cycle pulse when an out-of-range event is dropped
- ack_timeout_err  output  1  one-cycle pulse when a handshake is aborted

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous, active-low.
  - While rst_n is low: ev_ready=0, req=0, aer=0, xsel=0, busy=0, both error outputs 0, last_y_valid=0, state=IDLE.
- ack input:
  - ack passes through a 2-flop synchronizer; ack_s is the synchronized copy. All handshake decisions use ack_s.
- ev_ready:
  - Registered. High only in IDLE once the spacing counter has reached MIN_EVENT_CYCLES.
  - First high in the cycle after reset release.
- Accept (ev_valid && ev_ready):
  - Latch x, y, pol; ev_ready drops the next cycle; the spacing counter restarts at 0.
- Range check on accept:
  - If ev_x >= DVS_WIDTH_PXLS or ev_y >= DVS_HEIGHT_PXLS: pulse range_err, drop the event, stay in IDLE, leave bus outputs untouched.
- Routing on accept:
  - Y phase if !last_y_valid || y != last_y.
  - Otherwise go directly to the X phase.
- States: IDLE -> Y_SETUP -> Y_REQ -> Y_REL -> X_SETUP -> X_REQ -> X_REL -> IDLE.
- SETUP states:
  - On entry, drive the data word.
  - Y word: aer = {1'b0, y}, xsel = 0.
  - X word: aer = {x, pol}, xsel = 1.
  - After SETUP_CYCLES cycles, set req=1 and move to the REQ state.
  - aer/xsel stay constant until the next SETUP entry.
- REQ:
  - On the first cycle ack_s=1, set req=0 the next cycle and go to REL.
- REL:
  - Wait for ack_s=0, then advance.
  - After Y_REL: last_y = y, last_y_valid = 1.
- Ack timeout:
  - A counter runs in REQ. If it reaches ACK_TIMEOUT_CYCLES without ack_s: pulse ack_timeout_err, req=0, last_y_valid=0, go to X_REL to wait for ack_s low.
  - An aborted event is not retried.
- Y repeat timeout:
  - A saturating idle counter runs in IDLE.
  - At Y_REPEAT_TIMEOUT it clears last_y_valid.
  - It resets on every accept.
- Spacing counter:
  - Saturates at MIN_EVENT_CYCLES.
  - A handshake longer than MIN_EVENT_CYCLES imposes no extra gap.
- Outputs: busy = (state != IDLE); req is registered and glitch-free.
- ack high at the start of a REQ state (receiver stuck from a previous abort): handled as a normal ack.
- Reset asserted mid-handshake: all outputs return immediately to their reset values; the event is lost.

Test Plan:
- Reset release; event x=0x10, y=0x20, pol=1; receiver acks 3 cycles after req -> Y word aer=0x020/xsel=0, then X word aer=0x021/xsel=1. req rises exactly SETUP_CYCLES after each word is driven. ev_ready returns no earlier than 9 cycles after accept.
- Second event y=0x20, x=0x05, pol=0 within 100 idle cycles -> no Y word; X word aer=0x00A, xsel=1.
- Same y after 150 idle cycles -> Y word resent before the X word.
- Receiver never acks -> req held exactly 255 cycles, then falls; ack_timeout_err pulses once. Next event with the same y still sends Y.
- ev_x=400 (>= DVS_WIDTH_PXLS) -> range_err pulses, req stays 0, next valid event proceeds normally.
- Assert rst_n low while req=1 in X_REQ -> req, aer, xsel go to 0 asynchronously. After release, first event sends a Y word.

Source files
------------

// File: rtl/dvs_aer_event_transmitter.sv
// dvs_aer_event_transmitter
//   Drives a DVS-style AER bus (aer/xsel/req, four-phase handshake on ack)
//   from pixel events offered on a valid/ready interface. The Y word is
//   skipped when consecutive events share a row and the stored row is still
//   fresh. Accepts are spaced by at least MIN_EVENT_CYCLES cycles.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   ev_valid/ev_ready   event handshake (ev_ready registered)
//   ev_x, ev_y, ev_pol  event payload
//   ack                 receiver acknowledge (asynchronous, synchronized here)
//   aer, xsel, req      AER bus (all registered)
//   busy                state != IDLE
//   range_err           1-cycle pulse: out-of-range event dropped
//   ack_timeout_err     1-cycle pulse: handshake aborted on missing ack
module dvs_aer_event_transmitter #(
  parameter int unsigned SETUP_CYCLES       = 6,
  parameter int unsigned MIN_EVENT_CYCLES   = 9,
  parameter int unsigned Y_REPEAT_TIMEOUT   = 100,
  parameter int unsigned ACK_TIMEOUT_CYCLES = 255,
  parameter int unsigned DVS_WIDTH_PXLS     = 346,
  parameter int unsigned DVS_HEIGHT_PXLS    = 260
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [8:0] ev_x,
  input  logic [8:0] ev_y,
  input  logic       ev_pol,
  input  logic       ack,
  output logic [9:0] aer,
  output logic       xsel,
  output logic       req,
  output logic       busy,
  output logic       range_err,
  output logic       ack_timeout_err
);

  localparam int unsigned CMAX = (SETUP_CYCLES > ACK_TIMEOUT_CYCLES) ? SETUP_CYCLES : ACK_TIMEOUT_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned SPW  = $clog2(MIN_EVENT_CYCLES + 1);
  localparam int unsigned IW   = $clog2(Y_REPEAT_TIMEOUT + 1);

  localparam logic [CW-1:0]  SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0]  ATO_LAST   = CW'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [SPW-1:0] SP_MAX     = SPW'(MIN_EVENT_CYCLES);
  // ev_ready is registered, so it is raised one count early; the accept then
  // lands exactly MIN_EVENT_CYCLES after the previous one.
  localparam logic [SPW-1:0] READY_AT   = SPW'((MIN_EVENT_CYCLES > 0) ? MIN_EVENT_CYCLES - 1 : 0);
  localparam logic [IW-1:0]  IDLE_MAX   = IW'(Y_REPEAT_TIMEOUT);
  localparam logic [9:0]     X_LIM      = 10'(DVS_WIDTH_PXLS);
  localparam logic [9:0]     Y_LIM      = 10'(DVS_HEIGHT_PXLS);

  typedef enum logic [2:0] {
    IDLE, Y_SETUP, Y_REQ, Y_REL, X_SETUP, X_REQ, X_REL
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;     // setup length / ack timeout
  logic [SPW-1:0] sp_q, sp_d;       // cycles since last accept (saturating)
  logic [IW-1:0]  idle_q, idle_d;   // idle cycles since last accept (saturating)
  logic           ev_ready_q, ev_ready_d;
  logic           req_q, req_d;
  logic [9:0]     aer_q, aer_d;
  logic           xsel_q, xsel_d;
  logic           range_err_q, range_err_d;
  logic           ato_err_q, ato_err_d;
  logic [8:0]     last_y_q, last_y_d;
  logic           last_y_valid_q, last_y_valid_d;
  logic [8:0]     x_q, x_d, y_q, y_d;
  logic           pol_q, pol_d;
  logic [1:0]     ack_pipe_q;
  logic           ack_s, accept;

  assign ack_s  = ack_pipe_q[1];
  assign accept = ev_valid && ev_ready_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sp_d           = sp_q;
    idle_d         = idle_q;
    req_d          = req_q;
    aer_d          = aer_q;
    xsel_d         = xsel_q;
    range_err_d    = 1'b0;
    ato_err_d      = 1'b0;
    last_y_d       = last_y_q;
    last_y_valid_d = last_y_valid_q;
    x_d            = x_q;
    y_d            = y_q;
    pol_d          = pol_q;

    if (accept)              sp_d = '0;
    else if (sp_q != SP_MAX) sp_d = sp_q + 1'b1;

    // Stored row expires at the same edge the idle counter saturates, so an
    // accept never sees a stale last_y_valid.
    if (accept) begin
      idle_d = '0;
    end else if (state_q == IDLE && idle_q != IDLE_MAX) begin
      idle_d = idle_q + 1'b1;
      if (idle_q == IDLE_MAX - 1'b1) last_y_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          x_d   = ev_x;
          y_d   = ev_y;
          pol_d = ev_pol;
          cnt_d = '0;
          if ({1'b0, ev_x} >= X_LIM || {1'b0, ev_y} >= Y_LIM) begin
            range_err_d = 1'b1;
          end else if (!last_y_valid_q || ev_y != last_y_q) begin
            state_d = Y_SETUP;
            aer_d   = {1'b0, ev_y};
            xsel_d  = 1'b0;
          end else begin
            state_d = X_SETUP;
            aer_d   = {ev_x, ev_pol};
            xsel_d  = 1'b1;
          end
        end
      end
      Y_SETUP, X_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = (state_q == Y_SETUP) ? Y_REQ : X_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      Y_REQ, X_REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = (state_q == Y_REQ) ? Y_REL : X_REL;
        end else if (cnt_q == ATO_LAST) begin
          // Abort: drop the event, forget the row, wait for ack to be low.
          req_d          = 1'b0;
          ato_err_d      = 1'b1;
          last_y_valid_d = 1'b0;
          state_d        = X_REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      Y_REL: begin
        if (!ack_s) begin
          last_y_d       = y_q;
          last_y_valid_d = 1'b1;
          state_d        = X_SETUP;
          cnt_d          = '0;
          aer_d          = {x_q, pol_q};
          xsel_d         = 1'b1;
        end
      end
      X_REL: begin
        if (!ack_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ev_ready_d = (state_d == IDLE) && (sp_d >= READY_AT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      sp_q           <= SP_MAX;
      idle_q         <= '0;
      ev_ready_q     <= 1'b0;
      req_q          <= 1'b0;
      aer_q          <= '0;
      xsel_q         <= 1'b0;
      range_err_q    <= 1'b0;
      ato_err_q      <= 1'b0;
      last_y_q       <= '0;
      last_y_valid_q <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      pol_q          <= 1'b0;
      ack_pipe_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sp_q           <= sp_d;
      idle_q         <= idle_d;
      ev_ready_q     <= ev_ready_d;
      req_q          <= req_d;
      aer_q          <= aer_d;
      xsel_q         <= xsel_d;
      range_err_q    <= range_err_d;
      ato_err_q      <= ato_err_d;
      last_y_q       <= last_y_d;
      last_y_valid_q <= last_y_valid_d;
      x_q            <= x_d;
      y_q            <= y_d;
      pol_q          <= pol_d;
      ack_pipe_q     <= {ack_pipe_q[0], ack};
    end
  end

  assign ev_ready        = ev_ready_q;
  assign req             = req_q;
  assign aer             = aer_q;
  assign xsel            = xsel_q;
  assign busy            = (state_q != IDLE);
  assign range_err       = range_err_q;
  assign ack_timeout_err = ato_err_q;

endmodule

// File: tb/tb_dvs_aer_event_transmitter.sv
// Directed bench for dvs_aer_event_transmitter: acts as the AER receiver,
// checks word contents, setup-to-req timing, Y suppression/expiry, ack
// timeout, range drop, accept spacing and asynchronous reset.
module tb_dvs_aer_event_transmitter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_ready;
  logic [8:0] ev_x = '0;
  logic [8:0] ev_y = '0;
  logic       ev_pol = 1'b0;
  logic       ack = 1'b0;
  logic [9:0] aer;
  logic       xsel, req, busy, range_err, ack_timeout_err;

  int n_chk = 0;
  int n_err = 0;
  int n_ato = 0;
  int n_rerr = 0;
  int cyc = 0;
  int prev_acc = 0;
  int last_gap = 0;

  dvs_aer_event_transmitter dut (
    .clk(clk), .rst_n(rst_n),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_x(ev_x), .ev_y(ev_y), .ev_pol(ev_pol),
    .ack(ack), .aer(aer), .xsel(xsel), .req(req), .busy(busy),
    .range_err(range_err), .ack_timeout_err(ack_timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ev_valid && ev_ready) begin
      last_gap <= cyc - prev_acc;
      prev_acc <= cyc;
    end
  end

  always @(negedge clk) begin
    if (ack_timeout_err) n_ato <= n_ato + 1;
    if (range_err)       n_rerr <= n_rerr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_ev(input logic [8:0] x, input logic [8:0] y, input logic p);
    int k;
    ev_x = x; ev_y = y; ev_pol = p; ev_valid = 1'b1;
    k = 0;
    while (!ev_ready && k < 200) begin @(negedge clk); k++; end
    chk("accept", ev_ready, 1);
    @(posedge clk); #1 ev_valid = 1'b0;
    @(negedge clk);
  endtask

  // Called at the first negedge after a word was driven.
  task automatic do_hs(input string tag, input logic [9:0] ea, input logic ex, input int ack_dly);
    int k;
    chk({tag, "_aer"}, aer, ea);
    chk({tag, "_xsel"}, xsel, ex);
    k = 0;
    while (!req && k < 50) begin @(negedge clk); k++; end
    chk({tag, "_setup"}, k, 6);
    repeat (ack_dly) @(negedge clk);
    ack = 1'b1;
    k = 0;
    while (req && k < 50) begin @(negedge clk); k++; end
    chk({tag, "_reqfall"}, req, 0);
    chk({tag, "_aer_held"}, aer, ea);
    ack = 1'b0;
  endtask

  task automatic wait_xword(input string tag);
    int k;
    k = 0;
    while (!xsel && k < 50) begin @(negedge clk); k++; end
    chk({tag, "_xword"}, xsel, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 50) begin @(negedge clk); k++; end
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int k;
    // reset state
    #12;
    chk("rst_ready", ev_ready, 0);
    chk("rst_req", req, 0);
    chk("rst_aer", aer, 0);
    chk("rst_xsel", xsel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {range_err, ack_timeout_err}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", ev_ready, 1);

    // 1: full Y + X handshake
    send_ev(9'h010, 9'h020, 1'b1);
    chk("t1_ready_low", ev_ready, 0);
    chk("t1_busy", busy, 1);
    do_hs("t1y", 10'h020, 1'b0, 3);
    wait_xword("t1");
    do_hs("t1x", 10'h021, 1'b1, 3);
    wait_idle("t1");

    // 2: same row soon after -> X only
    send_ev(9'h005, 9'h020, 1'b0);
    chk("t2_gap_ge9", (last_gap >= 9), 1);
    do_hs("t2x", 10'h00A, 1'b1, 2);
    wait_idle("t2");

    // 3: same row after 150 idle cycles -> Y resent
    repeat (150) @(negedge clk);
    send_ev(9'h007, 9'h020, 1'b1);
    do_hs("t3y", 10'h020, 1'b0, 1);
    wait_xword("t3");
    do_hs("t3x", 10'h00F, 1'b1, 1);
    wait_idle("t3");

    // 4: receiver never acks during Y -> abort after 255 req cycles
    send_ev(9'h003, 9'h030, 1'b0);
    chk("t4_aer", aer, 10'h030);
    k = 0;
    while (!req && k < 50) begin @(negedge clk); k++; end
    chk("t4_setup", k, 6);
    k = 0;
    while (req && k < 400) begin @(negedge clk); k++; end
    chk("t4_req_len", k, 255);
    chk("t4_ato_pulse", ack_timeout_err, 1);
    wait_idle("t4");
    @(negedge clk);
    chk("t4_ato_count", n_ato, 1);
    // row 0x30 was never completed: Y must be sent
    send_ev(9'h008, 9'h030, 1'b0);
    do_hs("t4y", 10'h030, 1'b0, 2);
    wait_xword("t4");
    do_hs("t4x", 10'h010, 1'b1, 2);
    wait_idle("t4b");

    // 5: out-of-range x dropped; next event accepted exactly 9 cycles later
    send_ev(9'd400, 9'h005, 1'b1);
    chk("t5_rerr", range_err, 1);
    chk("t5_req", req, 0);
    chk("t5_busy", busy, 0);
    chk("t5_aer_untouched", aer, 10'h010);
    send_ev(9'h001, 9'h021, 1'b1);
    chk("t5_gap", last_gap, 9);
    chk("t5_rerr_count", n_rerr, 1);
    do_hs("t5y", 10'h021, 1'b0, 2);
    wait_xword("t5");
    do_hs("t5x", 10'h003, 1'b1, 2);
    wait_idle("t5");

    // 6: reset during X_REQ, then first event resends Y
    send_ev(9'h002, 9'h021, 1'b0);
    chk("t6_xonly", {xsel, aer}, {1'b1, 10'h004});
    k = 0;
    while (!req && k < 50) begin @(negedge clk); k++; end
    chk("t6_req_up", req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", req, 0);
    chk("t6_rst_aer", aer, 0);
    chk("t6_rst_xsel", xsel, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", ev_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    send_ev(9'h002, 9'h021, 1'b0);
    do_hs("t6y", 10'h021, 1'b0, 2);
    wait_xword("t6");
    do_hs("t6x", 10'h004, 1'b1, 2);
    wait_idle("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
